// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//     - bin2bcd_state_t : converter FSM states
//     - ADD3_THRESHOLD  : digit value from which the +3 correction applies
//     - min_digits()    : smallest BCD digit count that can represent every
//                         unsigned value of a given binary width
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        SHIFT  = 2'd2
    } bin2bcd_state_t;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Number of decimal digits of (2^width - 1). Evaluated at elaboration.
    function automatic int min_digits(input int width);
        logic [127:0] max_val;
        int           d;
        max_val = '0;
        for (int i = 0; i < width && i < 128; i++) begin
            max_val[i] = 1'b1;
        end
        d = 1;
        while (max_val >= 128'd10) begin
            max_val = max_val / 128'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational double-dabble correction cell for one BCD digit:
//   digits of 5 or more get +3 so the following left shift carries into the
//   next digit exactly when the doubled value reaches 10.
//   Ports:
//     digit     in  4  BCD digit before correction
//     digit_adj out 4  corrected digit (4-bit add, carry discarded)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    assign digit_adj = (digit >= ADD3_THRESHOLD) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Multi-cycle binary-to-BCD converter (shift-and-add-3) with a start/valid
//   handshake. One ADJUST + one SHIFT cycle per binary bit; all digits are
//   corrected in parallel. Latency 2*WIDTH cycles from the accepting edge.
//
//   Parameters:
//     WIDTH   binary operand width (>= 4)
//     DIGITS  number of BCD digits, must cover 2^WIDTH-1
//   Ports:
//     clk_i    in  1         clock
//     rst_i    in  1         asynchronous reset, active low
//     start_i  in  1         conversion request, sampled while idle
//     bin_i    in  WIDTH     unsigned operand, captured on the accepting edge
//     busy_o   out 1         conversion in progress
//     valid_o  out 1         one-cycle pulse, bcd_o updated at this edge
//     bcd_o    out 4*DIGITS  packed BCD result, digit k at [4k+3:4k]
//     blank_o  out DIGITS    leading-zero mask (only with BIN2BCD_BLANK_EN)
//
//   Build option: define BIN2BCD_BLANK_EN to add blank_o. Bit k is set when
//   digit k and all higher digits are zero; bit 0 is never set.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start_i; result outputs hold last value
//   ADJUST | add 3 to every BCD digit >= 5
//   SHIFT  | shift register left by one, count down remaining bits
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_o
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 4) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH must be at least 4");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    bin2bcd_state_t   state, next_state;
    logic [TOT_W-1:0] sreg;
    logic [TOT_W-1:0] sreg_adj;
    logic [TOT_W-1:0] sreg_shl;
    logic [BCD_W-1:0] digits_adj;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             do_adj;
    logic             do_shift;
    logic             done;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (sreg[WIDTH + 4*k +: 4]),
            .digit_adj (digits_adj[4*k +: 4])
        );
    end

    assign sreg_adj = {digits_adj, sreg[WIDTH-1:0]};
    assign sreg_shl = {sreg[TOT_W-2:0], 1'b0};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        do_adj     = 1'b0;
        do_shift   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load       = 1'b1;
                    next_state = ADJUST;
                end
            end
            ADJUST: begin
                do_adj     = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (cnt == CNT_ONE) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = ADJUST;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sreg    <= '0;
            cnt     <= '0;
            bcd_o   <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            busy_o  <= (next_state != IDLE);
            valid_o <= done;
            if (load) begin
                sreg <= {{BCD_W{1'b0}}, bin_i};
                cnt  <= CNT_LOAD;
            end else if (do_adj) begin
                sreg <= sreg_adj;
            end else if (do_shift) begin
                sreg <= sreg_shl;
                cnt  <= cnt - CNT_ONE;
            end
            // Result is taken from the shifted value so it lands on the same
            // edge as the final shift.
            if (done) begin
                bcd_o <= sreg_shl[TOT_W-1:WIDTH];
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              upper_zero;

    always_comb begin
        blank_nxt  = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero   = upper_zero && (sreg_shl[WIDTH + 4*k +: 4] == 4'd0);
            blank_nxt[k] = upper_zero;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            blank_o <= '0;
        end else if (done) begin
            blank_o <= blank_nxt;
        end
    end
`else
    // No leading-zero mask in this build.
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [11:0] bin_i;
    logic        busy_o;
    logic        valid_o;
    logic [15:0] bcd_o;

    logic        start16;
    logic [15:0] bin16;
    logic        busy16;
    logic        valid16;
    logic [19:0] bcd16;

`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank_o;
    logic [4:0]  blank16;
`endif

    int errors = 0;
    int checks = 0;

    bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .bcd_o   (bcd_o)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank_o (blank_o)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start16),
        .bin_i   (bin16),
        .busy_o  (busy16),
        .valid_o (valid16),
        .bcd_o   (bcd16)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank_o (blank16)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until valid_o is seen; cycles counts edges including the
    // accepting one, -1 if the bound expires.
    task automatic wait_valid(input bit drop_start, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 1 && drop_start) start_i = 1'b0;
            if (valid_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        checks++;
        if (bcd_o !== 16'h0000) begin
            errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd_o);
        end
`ifdef BIN2BCD_BLANK_EN
        checks++;
        if (blank_o !== 4'b0000) begin
            errors++; $display("FAIL reset_blank: got %b expected 0000", blank_o);
        end
`endif
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_max();
        bit early = 1'b0;
        bin_i   = 12'd4095;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL max_busy_rise: got %b expected 1", busy_o);
        end
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (valid_o) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL max_early_valid: got %b expected 0", early);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL max_valid_at_24: got %b expected 1", valid_o);
        end
        checks++;
        if (bcd_o !== 16'h4095) begin
            errors++; $display("FAIL max_bcd: got %h expected 4095", bcd_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL max_busy_fall: got %b expected 0", busy_o);
        end
`ifdef BIN2BCD_BLANK_EN
        checks++;
        if (blank_o !== 4'b0000) begin
            errors++; $display("FAIL max_blank: got %b expected 0000", blank_o);
        end
`endif
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL max_valid_width: got %b expected 0", valid_o);
        end
        checks++;
        if (bcd_o !== 16'h4095) begin
            errors++; $display("FAIL max_bcd_hold: got %h expected 4095", bcd_o);
        end
    endtask

    task automatic test_zero();
        int c;
        bin_i   = 12'd0;
        start_i = 1'b1;
        wait_valid(1'b1, c);
        checks++;
        if (c !== 25) begin
            errors++; $display("FAIL zero_latency: got %0d expected 25", c);
        end
        checks++;
        if (bcd_o !== 16'h0000) begin
            errors++; $display("FAIL zero_bcd: got %h expected 0000", bcd_o);
        end
`ifdef BIN2BCD_BLANK_EN
        checks++;
        if (blank_o !== 4'b1110) begin
            errors++; $display("FAIL zero_blank: got %b expected 1110", blank_o);
        end
`endif
    endtask

    task automatic test_hold_start();
        int          pulses = 0;
        logic [15:0] got    = '0;
        bin_i   = 12'd1234;
        start_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        bin_i   = 12'd77;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) begin
                pulses++;
                got = bcd_o;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (got !== 16'h1234) begin
            errors++; $display("FAIL hold_bcd: got %h expected 1234", got);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL hold_idle: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        bin_i   = 12'd999;
        start_i = 1'b1;
        wait_valid(1'b0, c);
        checks++;
        if (c !== 25 || bcd_o !== 16'h0999) begin
            errors++; $display("FAIL b2b_first: got %0d/%h expected 25/0999", c, bcd_o);
        end
        wait_valid(1'b0, c);
        checks++;
        if (c !== 25 || bcd_o !== 16'h0999) begin
            errors++; $display("FAIL b2b_second: got %0d/%h expected 25/0999", c, bcd_o);
        end
        bin_i = 12'd1000;
        wait_valid(1'b0, c);
        checks++;
        if (c !== 25) begin
            errors++; $display("FAIL b2b_third_period: got %0d expected 25", c);
        end
        checks++;
        if (bcd_o !== 16'h1000) begin
            errors++; $display("FAIL b2b_third_bcd: got %h expected 1000", bcd_o);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        bit seen = 1'b0;
        bin_i   = 12'd42;
        start_i = 1'b1;
        wait_valid(1'b1, c);
        checks++;
        if (bcd_o !== 16'h0042) begin
            errors++; $display("FAIL rmid_prev: got %h expected 0042", bcd_o);
        end
        bin_i   = 12'd4095;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (bcd_o !== 16'h0000) begin
            errors++; $display("FAIL rmid_bcd_async: got %h expected 0000", bcd_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL rmid_busy_async: got %b expected 0", busy_o);
        end
        tick();
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rmid_no_valid: got %b expected 0", seen);
        end
        bin_i   = 12'd4095;
        start_i = 1'b1;
        wait_valid(1'b1, c);
        checks++;
        if (c !== 25 || bcd_o !== 16'h4095) begin
            errors++; $display("FAIL rmid_restart: got %0d/%h expected 25/4095", c, bcd_o);
        end
    endtask

    task automatic test_width16();
        logic [15:0] ops [2] = '{16'd65535, 16'd10000};
        logic [19:0] exps[2] = '{20'h65535, 20'h10000};
        for (int t = 0; t < 2; t++) begin
            int c = -1;
            bin16   = ops[t];
            start16 = 1'b1;
            for (int i = 1; i <= 100; i++) begin
                tick();
                if (i == 1) start16 = 1'b0;
                if (valid16) begin
                    c = i;
                    break;
                end
            end
            checks++;
            if (c !== 33) begin
                errors++; $display("FAIL w16_latency_%0d: got %0d expected 33", t, c);
            end
            checks++;
            if (bcd16 !== exps[t]) begin
                errors++; $display("FAIL w16_bcd_%0d: got %h expected %h", t, bcd16, exps[t]);
            end
        end
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;
        bin_i   = '0;
        start16 = 1'b0;
        bin16   = '0;
        test_reset();
        test_max();
        test_zero();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
